// File: rtl/if_id_fetch_queue_if.sv
// IF->ID fetch queue bus: fetch push side, ID head side, status.
// master = IF/ID/hazard side driving requests, slave = the queue.
interface if_id_fetch_queue_if #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] Instruction_IN;
    logic [WIDTH-1:0] InstructionAddressPlus4_IN;
    logic             FetchValid_IN;
    logic             FLUSH_IN;
    logic             STALL_IN;
    logic [WIDTH-1:0] Instruction_OUT;
    logic [WIDTH-1:0] InstructionAddressPlus4_OUT;
    logic             Valid_OUT;
    logic             Full_OUT;
    logic [CW-1:0]    Count_OUT;
    logic [31:0]      StallCycles_OUT;

    modport master (
        output Instruction_IN, InstructionAddressPlus4_IN,
        output FetchValid_IN, FLUSH_IN, STALL_IN,
        input  Instruction_OUT, InstructionAddressPlus4_OUT,
        input  Valid_OUT, Full_OUT, Count_OUT, StallCycles_OUT
    );

    modport slave (
        input  Instruction_IN, InstructionAddressPlus4_IN,
        input  FetchValid_IN, FLUSH_IN, STALL_IN,
        output Instruction_OUT, InstructionAddressPlus4_OUT,
        output Valid_OUT, Full_OUT, Count_OUT, StallCycles_OUT
    );
endinterface

// File: rtl/if_id_fetch_queue.sv
// IF->ID decoupling FIFO with flush, back-pressure and stall counter.
// Optional same-cycle bypass when empty: define IFQ_BYPASS_EN.
module if_id_fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic CLOCK,
    input  logic RESET,
    if_id_fetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_instr [DEPTH];
    logic [WIDTH-1:0] r_pc4   [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [31:0]      r_stall;

    logic w_nonempty;
    logic w_full;
    logic w_byp;
    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_wr;
    logic w_rd;

    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == CW'(DEPTH));

`ifdef IFQ_BYPASS_EN
    assign w_byp = !w_nonempty && bus.FetchValid_IN && !bus.FLUSH_IN;
`else
    assign w_byp = 1'b0;
`endif

    assign w_valid = w_nonempty || w_byp;
    assign w_push  = bus.FetchValid_IN && !w_full && !bus.FLUSH_IN;
    assign w_pop   = w_valid && !bus.STALL_IN && !bus.FLUSH_IN;
    // A bypassed fetch consumed this cycle never touches storage.
    assign w_wr    = w_push && !(w_byp && w_pop);
    assign w_rd    = w_pop && !w_byp;

    // Head selection: stored entry, else bypassed fetch, else NOP.
    always_comb begin
        bus.Instruction_OUT             = '0;
        bus.InstructionAddressPlus4_OUT = '0;
        if (w_nonempty) begin
            bus.Instruction_OUT             = r_instr[r_rptr];
            bus.InstructionAddressPlus4_OUT = r_pc4[r_rptr];
        end else if (w_byp) begin
            bus.Instruction_OUT             = bus.Instruction_IN;
            bus.InstructionAddressPlus4_OUT = bus.InstructionAddressPlus4_IN;
        end
    end

    assign bus.Valid_OUT       = w_valid;
    assign bus.Full_OUT        = w_full;
    assign bus.Count_OUT       = r_count;
    assign bus.StallCycles_OUT = r_stall;

    // Entry storage; contents need no reset.
    always_ff @(posedge CLOCK) begin
        if (w_wr) begin
            r_instr[r_wptr] <= bus.Instruction_IN;
            r_pc4[r_wptr]   <= bus.InstructionAddressPlus4_IN;
        end
    end

    // Pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.FLUSH_IN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) r_rptr <= r_rptr + AW'(1);
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of cycles where ID holds a valid head.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_stall <= '0;
        end else if (w_valid && bus.STALL_IN && !bus.FLUSH_IN
                     && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Scoreboard bench for if_id_fetch_queue (DEPTH=2, default build).
// Stimulus queues expected entries; a monitor checks each ID consume.
module tb_if_id_fetch_queue;
    localparam int DEPTH = 2;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   consumed;
    logic [63:0] exp_q[$];

    if_id_fetch_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    if_id_fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] ins,
                         input logic [31:0] pc, input logic st,
                         input logic fl);
        bus.FetchValid_IN              = fv;
        bus.Instruction_IN             = ins;
        bus.InstructionAddressPlus4_IN = pc;
        bus.STALL_IN                   = st;
        bus.FLUSH_IN                   = fl;
    endtask

    // Push expected entry and drive it as a fetch.
    task automatic fetch(input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic accept);
        drive(1'b1, ins, pc, st, 1'b0);
        if (accept) exp_q.push_back({ins, pc});
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ID consume must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.Valid_OUT && !bus.STALL_IN && !bus.FLUSH_IN) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got %h want none",
                         bus.Instruction_OUT);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("pop_instr", {32'd0, bus.Instruction_OUT},
                    {32'd0, e[63:32]});
                chk("pop_pc4", {32'd0, bus.InstructionAddressPlus4_OUT},
                    {32'd0, e[31:0]});
                consumed++;
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        consumed = 0;
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), $urandom, $urandom, 1'($urandom),
                  1'($urandom));
            @(negedge clk);
            chk("rst_valid", {63'd0, bus.Valid_OUT}, 64'd0);
            chk("rst_count", {62'd0, bus.Count_OUT}, 64'd0);
            chk("rst_full", {63'd0, bus.Full_OUT}, 64'd0);
            chk("rst_instr", {32'd0, bus.Instruction_OUT}, 64'd0);
            chk("rst_pc4", {32'd0, bus.InstructionAddressPlus4_OUT}, 64'd0);
            chk("rst_stall", {32'd0, bus.StallCycles_OUT}, 64'd0);
            next();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {63'd0, bus.Valid_OUT}, 64'd0);
        chk("post_rst_count", {62'd0, bus.Count_OUT}, 64'd0);
        next();

        // Streaming: six fetches, no stall
        for (int k = 0; k < 6; k++) begin
            fetch(32'h2008_0001 + 32'(k), 32'hBFC0_0004 + 32'(4 * k),
                  1'b0, 1'b1);
            @(negedge clk);
            chk("stream_count", {62'd0, bus.Count_OUT},
                (k == 0) ? 64'd0 : 64'd1);
            next();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("stream_tail_count", {62'd0, bus.Count_OUT}, 64'd1);
        next();
        @(negedge clk);
        chk("stream_empty", {63'd0, bus.Valid_OUT}, 64'd0);
        chk("stream_nop", {32'd0, bus.Instruction_OUT}, 64'd0);
        next();

        // Fill and back-pressure
        fetch(32'hA000_0001, 32'h0000_1004, 1'b1, 1'b1);
        next();
        fetch(32'hA000_0002, 32'h0000_1008, 1'b1, 1'b1);
        @(negedge clk);
        chk("fill_count1", {62'd0, bus.Count_OUT}, 64'd1);
        chk("fill_full1", {63'd0, bus.Full_OUT}, 64'd0);
        next();
        fetch(32'hA000_0003, 32'h0000_100C, 1'b1, 1'b0);
        @(negedge clk);
        chk("fill_full", {63'd0, bus.Full_OUT}, 64'd1);
        chk("fill_count2", {62'd0, bus.Count_OUT}, 64'd2);
        chk("fill_stall1", {32'd0, bus.StallCycles_OUT}, 64'd1);
        next();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("fill_hold_count", {62'd0, bus.Count_OUT}, 64'd2);
        chk("fill_stall2", {32'd0, bus.StallCycles_OUT}, 64'd2);
        next();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("drain_full", {63'd0, bus.Full_OUT}, 64'd1);
        chk("drain_stall3", {32'd0, bus.StallCycles_OUT}, 64'd3);
        next();
        @(negedge clk);
        chk("drain_full_drop", {63'd0, bus.Full_OUT}, 64'd0);
        chk("drain_count1", {62'd0, bus.Count_OUT}, 64'd1);
        next();
        @(negedge clk);
        chk("drain_empty", {62'd0, bus.Count_OUT}, 64'd0);
        next();

        // Flush with a fetch presented in the same cycle
        fetch(32'hB000_0001, 32'h0000_2004, 1'b1, 1'b1);
        next();
        fetch(32'hB000_0002, 32'h0000_2008, 1'b1, 1'b1);
        next();
        drive(1'b1, 32'hB000_0003, 32'h0000_200C, 1'b1, 1'b1);
        exp_q.delete();
        @(negedge clk);
        chk("flush_pre_count", {62'd0, bus.Count_OUT}, 64'd2);
        chk("flush_pre_stall", {32'd0, bus.StallCycles_OUT}, 64'd4);
        next();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("flush_count", {62'd0, bus.Count_OUT}, 64'd0);
        chk("flush_valid", {63'd0, bus.Valid_OUT}, 64'd0);
        chk("flush_instr", {32'd0, bus.Instruction_OUT}, 64'd0);
        chk("flush_stall_kept", {32'd0, bus.StallCycles_OUT}, 64'd4);
        next();

        // Wrap-around: count oscillates 1 <-> 2
        fetch(32'hC000_0000, 32'h0000_3000, 1'b0, 1'b1);
        next();
        for (int j = 1; j <= 5; j++) begin
            fetch(32'hC000_0000 + 32'(j), 32'h0000_3000 + 32'(4 * j),
                  1'b1, 1'b1);
            @(negedge clk);
            chk("wrap_count_lo", {62'd0, bus.Count_OUT}, 64'd1);
            next();
            fetch(32'hDEAD_0000 + 32'(j), 32'h0000_4000, 1'b0, 1'b0);
            @(negedge clk);
            chk("wrap_count_hi", {62'd0, bus.Count_OUT}, 64'd2);
            chk("wrap_full", {63'd0, bus.Full_OUT}, 64'd1);
            next();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("wrap_tail_count", {62'd0, bus.Count_OUT}, 64'd1);
        chk("wrap_stall", {32'd0, bus.StallCycles_OUT}, 64'd9);
        next();
        @(negedge clk);
        chk("wrap_empty", {62'd0, bus.Count_OUT}, 64'd0);
        next();

        // Mid-operation asynchronous reset while full
        fetch(32'hE000_0001, 32'h0000_5004, 1'b1, 1'b1);
        next();
        fetch(32'hE000_0002, 32'h0000_5008, 1'b1, 1'b1);
        next();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("mid_full", {63'd0, bus.Full_OUT}, 64'd1);
        #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", {62'd0, bus.Count_OUT}, 64'd0);
        chk("mid_rst_full", {63'd0, bus.Full_OUT}, 64'd0);
        chk("mid_rst_valid", {63'd0, bus.Valid_OUT}, 64'd0);
        chk("mid_rst_instr", {32'd0, bus.Instruction_OUT}, 64'd0);
        chk("mid_rst_stall", {32'd0, bus.StallCycles_OUT}, 64'd0);
        next();
        rst_n = 1'b1;
        next();

        chk("sb_leftover", 64'(exp_q.size()), 64'd0);
        chk("sb_consumed", 64'(consumed), 64'd14);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_id_fetch_queue.md
# if_id_fetch_queue

Decoupling queue between the IF stage and the ID stage of the MIPS pipeline. It captures each fetched instruction word from instruction memory, together with its PC+4 from IF, into a small circular FIFO. It presents the oldest entry to ID and back-pressures IF through `Full_OUT`, which drives IF's `STALL`. A flush discards all queued entries when ID redirects the PC.

## Interface
- `DEPTH`, default 2: number of entries; power of two, 2..8.
- `WIDTH`, default 32: instruction and address width.
- `CLOCK`  in  1  system clock; all state updates on rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `Instruction_IN`  in  WIDTH  instruction word from IM for the current fetch.
- `InstructionAddressPlus4_IN`  in  WIDTH  PC+4 of the current fetch, from IF.
- `FetchValid_IN`  in  1  IF presents a valid fetch this cycle.
- `FLUSH_IN`  in  1  discard all entries; asserted by ID on a taken redirect.
- `STALL_IN`  in  1  ID cannot consume this cycle (hazard unit).
- `Instruction_OUT`  out  WIDTH  head instruction; `32'h0` (NOP) when empty.
- `InstructionAddressPlus4_OUT`  out  WIDTH  head PC+4; 0 when empty.
- `Valid_OUT`  out  1  head entry is valid.
- `Full_OUT`  out  1  count == DEPTH; drives IF `STALL`.
- `Count_OUT`  out  $clog2(DEPTH)+1  occupied entries.
- `StallCycles_OUT`  out  32  cycles with `Valid_OUT && STALL_IN`.

## Operation
- Storage: DEPTH entries of {instruction, PC+4}. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH. Count is held explicitly.
- push = `FetchValid_IN && !Full_OUT && !FLUSH_IN`.
- pop = `Valid_OUT && !STALL_IN && !FLUSH_IN`.
- push only: write the entry at the write pointer, advance the write pointer, count+1.
- pop only: advance the read pointer, count−1.
- push and pop together: both pointers advance; count is unchanged. This is legal whenever count ≥ 1 and count < DEPTH.
- `Full_OUT` is derived from the registered count only. When the queue is full, push is blocked even if a pop occurs in the same cycle; the fetch is retried because IF is stalled.
- push while empty and pop: pop is impossible because `Valid_OUT` = 0. The entry is written and becomes the head next cycle.
- FLUSH: both pointers and count go to 0, and the same-cycle push is dropped. Flush has priority over push and pop. `StallCycles_OUT` is not cleared by flush.
- Head outputs are combinational reads at the read pointer, gated to 0 when count == 0.
- `StallCycles_OUT` increments by 1 per cycle when `Valid_OUT && STALL_IN && !FLUSH_IN`. It saturates at `32'hFFFFFFFF`.
- Reset (async, `RESET` low) sets pointers, count and stall counter to 0. As a result `Valid_OUT`=0, `Full_OUT`=0, `Count_OUT`=0 and head outputs = 0. Storage contents are don't-care. Reset during any operation aborts it immediately.

## Timing
- Default latency: a fetch pushed at edge N is visible on the outputs after edge N (1 cycle). It is consumed at the first later edge where `!STALL_IN`.
- Back-pressure: `Full_OUT` rises the cycle after the DEPTH-th push. It falls the cycle after the first pop from full.
- Flush: outputs read empty the cycle after the flush edge. A fetch presented in the flush cycle is lost; IF re-fetches from the redirect target.
- Throughput: one instruction per cycle with no stalls and DEPTH ≥ 2.

## Configuration
- `IFQ_BYPASS_EN` defined: when count == 0 and `FetchValid_IN` and `!FLUSH_IN`, the outputs show `Instruction_IN`/`InstructionAddressPlus4_IN` combinationally and `Valid_OUT`=1 in the same cycle.
  - If `!STALL_IN` that cycle, the entry is consumed directly and not written. Count stays 0.
  - If `STALL_IN`, the entry is written normally.
- `IFQ_BYPASS_EN` undefined: no bypass; the minimum latency is 1 cycle as above.

## Test plan
- Reset: hold `RESET`=0 with random inputs → all outputs 0; release → `Valid_OUT`=0, `Count_OUT`=0.
- Streaming: 6 consecutive fetches `32'h20080001..6` with PC+4 `BFC00004..18` and `STALL_IN`=0 → ID sees them in order. Each appears one cycle after its push (same cycle with bypass). Count ≤ 1.
- Fill and back-pressure: DEPTH=2, `STALL_IN`=1, 3 fetches → `Full_OUT`=1 after 2 pushes and the 3rd is not written. `StallCycles_OUT` increments every held cycle. Release stall → entries drain in order and `Full_OUT` drops the cycle after the first pop.
- Flush: 2 entries queued, fetch presented and `FLUSH_IN`=1 in the same cycle → next cycle count=0, `Instruction_OUT`=0, and the presented fetch is absent.
- Wrap-around: 10 push/pop cycles with count oscillating between 1 and DEPTH → data order preserved across pointer wrap, with no duplicate or lost entries.
- Mid-operation reset: assert `RESET` low between clock edges while full → outputs clear immediately without waiting for the clock edge.
